// File: rtl/shift_buffer_arbiter.sv
`timescale 1ns/1ps
// shift_buffer_arbiter: round-robin owner of one shared shift_buffer, granting a full burst per requester.
// Latency: one IDLE arbitration cycle, then one word per cycle; tag pulses the cycle after the last word.
// Backpressure: only the owner sees ready; an owner dropping valid stalls the burst with the grant held.
module shift_buffer_arbiter #(
  parameter int buffer_SIZE  = 8,
  parameter int buffer_WIDTH = 32,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              in_valid_i,
  input  logic [NUM_REQ*buffer_WIDTH-1:0] in_data_i,
  output logic [NUM_REQ-1:0]              in_ready_o,
  output logic                            wr_en_o,
  output logic [buffer_WIDTH-1:0]         wr_data_o,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            busy_o,
  output logic                            tag_valid_o,
  output logic [ID_W-1:0]                 tag_id_o
);

  localparam int              CNT_W    = $clog2(buffer_SIZE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(buffer_SIZE - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   tag_id_q, tag_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]   sel_id, cand;
  logic              sel_found;
  logic              xfer, burst_end;

  // Round-robin pick: first valid requester searching upward from last_grant+1, wrapping.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!sel_found && in_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // A word moves only while bursting and the owner offers one; the last word closes the burst.
  always_comb begin
    xfer      = (state_q == BURST) && in_valid_i[grant_q];
    burst_end = xfer && (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: requests are sampled only in IDLE; a burst leaves only on its final word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (sel_found) state_d = BURST;
      BURST: if (burst_end) state_d = IDLE;
    endcase
  end

  // Outputs: owner handshake and write port, all zero outside BURST.
  always_comb begin
    in_ready_o = '0;
    grant_o    = '0;
    busy_o     = 1'b0;
    wr_en_o    = 1'b0;
    wr_data_o  = '0;
    if (state_q == BURST) begin
      grant_o[grant_q]    = 1'b1;
      in_ready_o[grant_q] = 1'b1;
      busy_o              = 1'b1;
      wr_en_o             = xfer;
      if (xfer) wr_data_o = in_data_i[int'(grant_q)*buffer_WIDTH +: buffer_WIDTH];
    end
  end

  // Bookkeeping: latch the winner, count words, publish the tag when a burst completes.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tag_valid_d  = 1'b0;
    tag_id_d     = tag_id_q;
    if (state_q == IDLE) begin
      if (sel_found) begin
        grant_d = sel_id;
        cnt_d   = '0;
      end
    end else if (xfer) begin
      if (burst_end) begin
        cnt_d        = '0;
        last_grant_d = grant_q;
        tag_valid_d  = 1'b1;
        tag_id_d     = grant_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Bookkeeping registers; last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= ID_LAST;
      cnt_q        <= '0;
      tag_valid_q  <= 1'b0;
      tag_id_q     <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
    end
  end

  assign tag_valid_o = tag_valid_q;
  assign tag_id_o    = tag_id_q;

endmodule

// File: tb/tb_shift_buffer_arbiter.sv
`timescale 1ns/1ps
// Bench for shift_buffer_arbiter: default instance against a cycle model, plus a small 4x2 instance.
module tb_shift_buffer_arbiter;
  localparam int SZ = 8, W = 32, NR = 4, IDW = 2;
  localparam int SZ2 = 4, NR2 = 2, IDW2 = 1;
  localparam int OW = 2*NR + W + 3 + IDW;
  localparam int OW2 = 2*NR2 + W + 3 + IDW2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] in_valid;
  logic [NR*W-1:0] in_data;
  logic [NR-1:0] in_ready, grant;
  logic wr_en, busy, tag_valid;
  logic [W-1:0] wr_data;
  logic [IDW-1:0] tag_id;

  logic [NR2-1:0] s_in_valid, s_in_ready, s_grant;
  logic [NR2*W-1:0] s_in_data;
  logic s_wr_en, s_busy, s_tag_valid;
  logic [W-1:0] s_wr_data;
  logic [IDW2-1:0] s_tag_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_buffer_arbiter #(.buffer_SIZE(SZ), .buffer_WIDTH(W), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .wr_en_o(wr_en), .wr_data_o(wr_data), .grant_o(grant),
    .busy_o(busy), .tag_valid_o(tag_valid), .tag_id_o(tag_id));

  shift_buffer_arbiter #(.buffer_SIZE(SZ2), .buffer_WIDTH(W), .NUM_REQ(NR2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(s_in_valid), .in_data_i(s_in_data),
    .in_ready_o(s_in_ready), .wr_en_o(s_wr_en), .wr_data_o(s_wr_data), .grant_o(s_grant),
    .busy_o(s_busy), .tag_valid_o(s_tag_valid), .tag_id_o(s_tag_id));

  // Behavioural model of the default instance plus the vector the buffer would assemble.
  logic m_busy, m_tagv, m_found;
  int m_owner, m_cnt, m_last, m_tagid, mk;
  logic [W-1:0] m_words [SZ];
  logic [SZ*W-1:0] m_vec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = NR - 1;
      m_tagv = 1'b0; m_tagid = 0;
    end else begin
      m_tagv = 1'b0;
      if (!m_busy) begin
        m_found = 1'b0;
        for (int i = 1; i <= NR; i++) begin
          mk = (m_last + i) % NR;
          if (!m_found && in_valid[mk]) begin
            m_found = 1'b1; m_owner = mk; m_busy = 1'b1; m_cnt = 0;
          end
        end
      end else if (in_valid[m_owner]) begin
        m_words[m_cnt] = in_data[m_owner*W +: W];
        if (m_cnt == SZ - 1) begin
          for (int j = 0; j < SZ; j++) m_vec[j*W +: W] = m_words[j];
          m_busy = 1'b0; m_last = m_owner; m_tagv = 1'b1; m_tagid = m_owner; m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // Words actually written by the DUT, ring-indexed per burst.
  logic [W-1:0] obs_words [SZ];
  int obs_n;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) obs_n = 0;
    else if (wr_en) begin
      obs_words[obs_n % SZ] = wr_data;
      obs_n = obs_n + 1;
    end
  end

  logic [OW-1:0] obs_now;
  assign obs_now = {in_ready, wr_en, wr_data, grant, busy, tag_valid, tag_id};
  logic [OW2-1:0] s_obs_now;
  assign s_obs_now = {s_in_ready, s_wr_en, s_wr_data, s_grant, s_busy, s_tag_valid, s_tag_id};

  function automatic logic [OW-1:0] model_exp();
    logic [NR-1:0] oh;
    logic xf;
    logic [W-1:0] d;
    oh = '0; xf = 1'b0; d = '0;
    if (m_busy) begin
      oh[m_owner] = 1'b1;
      xf = in_valid[m_owner];
      if (xf) d = in_data[m_owner*W +: W];
    end
    return {oh, xf, d, oh, m_busy, m_tagv, IDW'(m_tagid)};
  endfunction

  function automatic logic [SZ*W-1:0] obs_vec();
    logic [SZ*W-1:0] v;
    for (int k = 0; k < SZ; k++) v[k*W +: W] = obs_words[k];
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NR; k++) in_data[k*W +: W] = $urandom;
  endtask

  // Finish any burst in progress by feeding only the current owner.
  task automatic drain();
    for (int n = 0; n < 40 && m_busy; n++) begin
      next_cycle();
      in_valid = '0;
      if (m_busy) in_valid[m_owner] = 1'b1;
      rand_data();
      @(negedge clk);
    end
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drain_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '1; rand_data();
    s_in_valid = '0; s_in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", obs_now);
    end
    in_valid = '0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL reset_release got=%h want=0", obs_now);
    end
  endtask

  task automatic test_single();
    int word;
    logic [SZ*W-1:0] ev;
    logic ew;
    word = 1;
    for (int k = 0; k < SZ; k++) ev[k*W +: W] = W'(k + 1);
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      in_valid = (word <= SZ) ? 4'b0001 : 4'b0000;
      in_data = '0; in_data[0 +: W] = W'(word);
      @(negedge clk);
      checks++;
      if (obs_now !== model_exp()) begin
        errors++; $display("FAIL single_model c=%0d got=%h want=%h", c, obs_now, model_exp());
      end
      ew = (c >= 1 && c <= SZ);
      checks++;
      if (wr_en !== ew || (ew && wr_data !== W'(c))) begin
        errors++; $display("FAIL single_word c=%0d got wr_en=%b data=%0d want wr_en=%b data=%0d", c, wr_en, wr_data, ew, c);
      end
      if (c == SZ + 1) begin
        checks++;
        if (tag_valid !== 1'b1 || tag_id !== 2'd0) begin
          errors++; $display("FAIL single_tag got vld=%b id=%0d want vld=1 id=0", tag_valid, tag_id);
        end
        checks++;
        if (obs_vec() !== ev) begin
          errors++; $display("FAIL single_vector got=%h want=%h", obs_vec(), ev);
        end
      end
      if (in_ready[0] && in_valid[0]) word++;
    end
  endtask

  task automatic test_contention();
    int words, prev, want;
    words = 0; prev = 0;
    for (int c = 0; c < 60; c++) begin
      next_cycle();
      in_valid = 4'b0101; rand_data();
      @(negedge clk);
      checks++;
      if (obs_now !== model_exp()) begin
        errors++; $display("FAIL cont_model c=%0d got=%h want=%h", c, obs_now, model_exp());
      end
      checks++;
      if (in_ready[1] !== 1'b0 || in_ready[3] !== 1'b0) begin
        errors++; $display("FAIL cont_ready_leak got=%b want x0x0", in_ready);
      end
      if (wr_en) words++;
      if (tag_valid) begin
        want = (prev == 0) ? 2 : 0;
        checks++;
        if (words != SZ || int'(tag_id) != want) begin
          errors++; $display("FAIL cont_burst got words=%0d id=%0d want words=%0d id=%0d", words, tag_id, SZ, want);
        end
        checks++;
        if (obs_vec() !== m_vec) begin
          errors++; $display("FAIL cont_vector got=%h want=%h", obs_vec(), m_vec);
        end
        prev = want; words = 0;
      end
    end
    drain();
  endtask

  task automatic test_stall();
    int acc, gap;
    logic seen;
    acc = 0; gap = 3; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      in_valid = '0;
      in_valid[3] = (c > 0);
      if (acc == 4 && gap > 0) gap--;
      else in_valid[1] = (acc < SZ);
      rand_data();
      @(negedge clk);
      checks++;
      if (obs_now !== model_exp()) begin
        errors++; $display("FAIL stall_model c=%0d got=%h want=%h", c, obs_now, model_exp());
      end
      if (m_busy && m_owner == 1) begin
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0010 || in_ready[3] !== 1'b0) begin
          errors++; $display("FAIL stall_hold c=%0d got busy=%b grant=%b ready=%b want 1 0010 0010", c, busy, grant, in_ready);
        end
        if (!in_valid[1]) begin
          checks++;
          if (wr_en !== 1'b0) begin
            errors++; $display("FAIL stall_gap c=%0d got wr_en=%b want 0", c, wr_en);
          end
        end
      end
      if (tag_valid && !seen) begin
        seen = 1'b1;
        checks++;
        if (tag_id !== 2'd1 || obs_vec() !== m_vec) begin
          errors++; $display("FAIL stall_tag got id=%0d vec=%h want id=1 vec=%h", tag_id, obs_vec(), m_vec);
        end
      end
      if (in_ready[1] && in_valid[1]) acc++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL stall_done got no tag want tag 1");
    end
    drain();
  endtask

  task automatic test_wrap();
    int acc3, got;
    int tags[$];
    int exp_t[3];
    exp_t = '{3, 0, 3};
    acc3 = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      in_valid = (acc3 < SZ) ? 4'b1000 : 4'b1001;
      rand_data();
      @(negedge clk);
      checks++;
      if (obs_now !== model_exp()) begin
        errors++; $display("FAIL wrap_model c=%0d got=%h want=%h", c, obs_now, model_exp());
      end
      if (tag_valid) tags.push_back(int'(tag_id));
      if (in_ready[3] && in_valid[3]) acc3++;
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < tags.size()) ? tags[i] : -1;
      checks++;
      if (got != exp_t[i]) begin
        errors++; $display("FAIL wrap_order idx=%0d got=%0d want=%0d", i, got, exp_t[i]);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int acc;
    logic seen;
    acc = 0; seen = 1'b0;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      next_cycle();
      in_valid = 4'b0100; rand_data();
      @(negedge clk);
      if (in_ready[2] && in_valid[2]) acc++;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL rstmid_outputs got=%h want=0", obs_now);
    end
    @(negedge clk);
    checks++;
    if (obs_now !== '0) begin
      errors++; $display("FAIL rstmid_held got=%h want=0", obs_now);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      in_valid = seen ? 4'b0000 : 4'b0100; rand_data();
      @(negedge clk);
      checks++;
      if (obs_now !== model_exp()) begin
        errors++; $display("FAIL rstmid_model c=%0d got=%h want=%h", c, obs_now, model_exp());
      end
      if (tag_valid) begin
        seen = 1'b1;
        checks++;
        if (tag_id !== 2'd2 || obs_vec() !== m_vec) begin
          errors++; $display("FAIL rstmid_tag got id=%0d vec=%h want id=2 vec=%h", tag_id, obs_vec(), m_vec);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_done got no tag want tag 2");
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      next_cycle();
      in_valid = NR'($urandom_range(0, 15)); rand_data();
      @(negedge clk);
      checks++;
      if (obs_now !== model_exp()) begin
        errors++; $display("FAIL rand_model c=%0d got=%h want=%h", c, obs_now, model_exp());
      end
      if (tag_valid) begin
        checks++;
        if (obs_vec() !== m_vec) begin
          errors++; $display("FAIL rand_vector got=%h want=%h", obs_vec(), m_vec);
        end
      end
    end
    drain();
  endtask

  task automatic test_small();
    int word, ph;
    logic ew, etv;
    logic [IDW2-1:0] etid;
    logic [W-1:0] ed;
    logic [OW2-1:0] ex;
    word = 1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      s_in_valid = 2'b10;
      s_in_data = '0; s_in_data[W +: W] = W'(word);
      @(negedge clk);
      ph = c % (SZ2 + 1);
      ew = (ph != 0);
      etv = (ph == 0 && c > 0);
      etid = (c > SZ2) ? 1'b1 : 1'b0;
      ed = ew ? W'((c / (SZ2 + 1)) * SZ2 + ph) : '0;
      ex = {(ew ? 2'b10 : 2'b00), ew, ed, (ew ? 2'b10 : 2'b00), ew, etv, etid};
      checks++;
      if (s_obs_now !== ex) begin
        errors++; $display("FAIL small c=%0d got=%h want=%h", c, s_obs_now, ex);
      end
      if (s_in_ready[1] && s_in_valid[1]) word++;
    end
    next_cycle();
    s_in_valid = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
